myclint_mtime: RTL
==================

MYCLINT_MTIME -- requirements
Module: myclint_mtime

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus data width; only 32 is supported.
REQ-003 SHALL have parameter PRESCALE, default 16, meaning clk cycles per mtime tick in internal mode; legal range is 1 or more.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port reset, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-006 SHALL have port valid, input, 1 bit, the bus request.
REQ-007 SHALL have port address, input, ADDR_W bits; only address[3:2] is decoded.
REQ-008 SHALL have port wdata, input, DATA_W bits, the write data.
REQ-009 SHALL have port wstrb, input, DATA_W/8 bits, the byte write strobes; all zero means a read.
REQ-010 SHALL have port rdata, output, DATA_W bits, the read data.
REQ-011 SHALL have port ready, output, 1 bit, the request-complete pulse.
REQ-012 SHALL have port rt_clk, input, 1 bit, the external real-time clock; present only when MYCLINT_RTC_EXT_EN is defined.
REQ-013 SHALL have port mtime, output, 64 bits, the timer value fed to the downstream timer-compare block.
REQ-014 SHALL have port tick, output, 1 bit, a one-cycle pulse in the cycle mtime increments.

Function
REQ-015 SHALL provide this register map:
- 0x0 MTIME_LO: mtime[31:0].
- 0x4 MTIME_HI: mtime[63:32].
- 0x8 CTRL: bit0 = enable, reset value 1; other bits read 0.
- 0xC: reserved; reads return 0, writes are ignored.
REQ-016 SHALL accept a request when valid=1 and ready=0, and drive ready=1 for exactly one cycle on the next cycle.
- Reads: rdata is valid in that same ready cycle and holds until the next accepted read.
REQ-017 SHALL treat valid=1 while ready=1 as not accepted.
- With valid held high continuously, one request completes every 2 cycles.
REQ-018 SHALL apply writes byte-wise per wstrb to the addressed 32-bit half or CTRL, in the accept cycle.
REQ-019 SHALL latch mtime[63:32] into a HI shadow register when a MTIME_LO read is accepted.
- MTIME_HI reads return the shadow, not the live value, so a LO-then-HI read pair is coherent.
REQ-020 SHALL update the HI shadow on MTIME_HI writes as well as on MTIME_LO reads.
REQ-021 SHALL, in internal mode, count a prescaler 0..PRESCALE-1 while enable=1.
- tick is asserted in the cycle the count equals PRESCALE-1; the count then wraps to 0.
- PRESCALE=1 gives a tick every cycle.
REQ-022 SHALL freeze the prescaler (and therefore tick) while enable=0; the count resumes from its held value when enable returns to 1.
REQ-023 SHALL increment mtime by 1, modulo 2^64, on the clock edge following a tick cycle.
- 0xFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
REQ-024 SHALL give a write to MTIME_LO or MTIME_HI priority over a coincident tick.
- That cycle's increment is dropped; tick is still pulsed.
REQ-025 SHALL drive the mtime output directly from the register, with zero added latency.

Reset
REQ-026 SHALL, while reset=0, asynchronously clear mtime, the prescaler, the HI shadow, rdata, ready, tick and the synchronizer flops, and set enable to 1.
REQ-027 SHALL abort any request in flight when reset asserts mid-operation; no ready is issued for it after reset deasserts.

Configuration
REQ-028 SHALL, when MYCLINT_RTC_EXT_EN is defined, take the tick from rt_clk instead of the prescaler, and ignore PRESCALE:
- rt_clk passes through a 2-flop synchronizer followed by a rising-edge detector.
- tick is asserted 3 clk cycles after an rt_clk rising edge, gated by enable.
REQ-029 SHALL, when MYCLINT_RTC_EXT_EN is undefined, omit the rt_clk port and synchronizer entirely and use the internal prescaler.

Structure
REQ-030 SHALL take the register offsets (MTIME_LO, MTIME_HI, CTRL) and the CTRL enable bit index from shared package myclint_pkg; the downstream CLINT uses the same package.
REQ-031 SHALL place the synchronizer and edge detector in one sub-module, myclint_rtc_sync, instantiated only when MYCLINT_RTC_EXT_EN is defined.

Verification
REQ-032 SHALL cover tick rate and ready timing:
- PRESCALE=4, reset released, no bus traffic -> tick every 4th cycle; mtime=5 after 20 cycles.
- ready pulses exactly once per accepted request.
REQ-033 SHALL cover wrap-around: write LO=0xFFFF_FFFF and HI=0xFFFF_FFFF, then one tick -> mtime=0.
REQ-034 SHALL cover coherent split reads:
- mtime=0x0000_0000_FFFF_FFFF; read LO; tick; read HI.
- Required: LO returns 0xFFFF_FFFF and HI returns 0x0000_0000, while live mtime is 0x1_0000_0000.
REQ-035 SHALL cover write/tick collision: LO write of 0x10 in a tick cycle -> mtime=0x10 afterwards, not 0x11.
REQ-036 SHALL cover enable and mid-operation reset:
- CTRL=0 -> mtime holds for 100 cycles.
- reset pulsed low mid-request -> no ready; mtime=0; CTRL reads 1.
REQ-037 SHALL cover external mode: with MYCLINT_RTC_EXT_EN defined, a 32-clk-period rt_clk square wave -> one tick per rt_clk period, 3 cycles after each rising edge.

Source files
------------

// File: rtl/myclint_pkg.sv
// myclint_pkg -- definitions shared by the machine-timer block and the
// downstream CLINT compare logic.
//
// Contents:
//   - Byte offsets of the MTIME_LO / MTIME_HI / CTRL registers and the word
//     indices (address[3:2]) derived from them.
//   - Bit index of the CTRL enable bit.
//   - Register-select enum plus helpers for decoding a word index and for
//     merging byte-strobed write data into a 32-bit register.
package myclint_pkg;

   localparam int MYCLINT_REG_W = 32;

   localparam logic [3:0] MYCLINT_MTIME_LO_OFF = 4'h0;
   localparam logic [3:0] MYCLINT_MTIME_HI_OFF = 4'h4;
   localparam logic [3:0] MYCLINT_CTRL_OFF     = 4'h8;

   localparam logic [1:0] MYCLINT_IDX_LO   = MYCLINT_MTIME_LO_OFF[3:2];
   localparam logic [1:0] MYCLINT_IDX_HI   = MYCLINT_MTIME_HI_OFF[3:2];
   localparam logic [1:0] MYCLINT_IDX_CTRL = MYCLINT_CTRL_OFF[3:2];

   localparam int MYCLINT_CTRL_EN_BIT = 0;

   typedef enum logic [1:0] {
      SEL_MTIME_LO = 2'd0,
      SEL_MTIME_HI = 2'd1,
      SEL_CTRL     = 2'd2,
      SEL_RSVD     = 2'd3
   } myclint_sel_e;

   // Map a word index (address[3:2]) onto the register it selects.
   function automatic myclint_sel_e myclint_decode(input logic [1:0] idx);
      myclint_sel_e sel;
      if (idx == MYCLINT_IDX_LO) begin
         sel = SEL_MTIME_LO;
      end else if (idx == MYCLINT_IDX_HI) begin
         sel = SEL_MTIME_HI;
      end else if (idx == MYCLINT_IDX_CTRL) begin
         sel = SEL_CTRL;
      end else begin
         sel = SEL_RSVD;
      end
      return sel;
   endfunction

   // Replace the bytes of old_val whose strobe is set with the matching
   // bytes of wdata.
   function automatic logic [MYCLINT_REG_W-1:0] myclint_merge(
      input logic [MYCLINT_REG_W-1:0]   old_val,
      input logic [MYCLINT_REG_W-1:0]   wdata,
      input logic [MYCLINT_REG_W/8-1:0] wstrb
   );
      logic [MYCLINT_REG_W-1:0] res;
      for (int b = 0; b < MYCLINT_REG_W/8; b++) begin
         if (wstrb[b]) begin
            res[8*b +: 8] = wdata[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_val[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/myclint_rtc_sync.sv
// myclint_rtc_sync -- brings the external real-time clock into the clk
// domain and flags each of its rising edges.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   i_rt_clk in   external real-time clock (asynchronous to clk)
//   o_rise   out  one-clk pulse, two clk edges after an i_rt_clk rising edge
module myclint_rtc_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_rt_clk,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic w_rise;

   // Two-flop synchronizer plus a delayed copy for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_rt_clk;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign w_rise = r_sync & ~r_prev;
   assign o_rise = w_rise;

endmodule

// File: rtl/myclint_mtime.sv
// myclint_mtime -- 64-bit machine timer (mtime) with a small register port.
//
// Register map (address[3:2] decoded, offsets from myclint_pkg):
//   0x0 MTIME_LO  mtime[31:0]; a read also snapshots mtime[63:32]
//   0x4 MTIME_HI  reads return the snapshot; writes update mtime and snapshot
//   0x8 CTRL      bit0 = enable (reset 1)
//   0xC reserved  reads 0, writes ignored
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   rt_clk           external real-time clock (MYCLINT_RTC_EXT_EN only)
//   valid/address/wdata/wstrb  request; wstrb == 0 is a read
//   rdata/ready      response; ready pulses one cycle after acceptance
//   mtime            live timer value
//   tick             one-cycle pulse in the cycle before mtime increments
//
// Build option: define MYCLINT_RTC_EXT_EN to tick from rt_clk rising edges
// instead of the internal PRESCALE divider.
module myclint_mtime
   import myclint_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int PRESCALE = 16
) (
   input  logic                clk,
   input  logic                reset,
`ifdef MYCLINT_RTC_EXT_EN
   input  logic                rt_clk,
`endif
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic [63:0]         mtime,
   output logic                tick
);

   localparam int EN_BYTE = MYCLINT_CTRL_EN_BIT / 8;

   logic [63:0]       r_mtime;
   logic [31:0]       r_shadow;
   logic [31:0]       r_rdata;
   logic              r_ready;
   logic              r_tick;
   logic              r_en;

   logic              w_accept;
   logic              w_is_write;
   myclint_sel_e      w_sel;
   logic              w_wr_lo;
   logic              w_wr_hi;
   logic              w_wr_ctrl;
   logic              w_rd;
   logic [31:0]       w_lo_new;
   logic [31:0]       w_hi_new;
   logic [31:0]       w_ctrl_val;
   logic [31:0]       w_rd_data;
   logic              w_en_nxt;
   logic              w_tick_nxt;
   logic              w_unused_addr;

   assign w_unused_addr = ^{address[ADDR_W-1:4], address[1:0]};

   // Request decode: a request is taken only while no response is pending
   always_comb begin
      w_accept   = valid & ~r_ready;
      w_is_write = |wstrb;
      w_sel      = myclint_decode(address[3:2]);
      w_rd       = w_accept & ~w_is_write;
      w_wr_lo    = w_accept & w_is_write & (w_sel == SEL_MTIME_LO);
      w_wr_hi    = w_accept & w_is_write & (w_sel == SEL_MTIME_HI);
      w_wr_ctrl  = w_accept & w_is_write & (w_sel == SEL_CTRL);
      w_lo_new   = myclint_merge(r_mtime[31:0], wdata, wstrb);
      w_hi_new   = myclint_merge(r_mtime[63:32], wdata, wstrb);
   end

   // Enable value after this cycle, so tick lookahead sees a CTRL write at once
   always_comb begin
      if (w_wr_ctrl && wstrb[EN_BYTE]) begin
         w_en_nxt = wdata[MYCLINT_CTRL_EN_BIT];
      end else begin
         w_en_nxt = r_en;
      end
   end

   // Read mux; MTIME_HI returns the snapshot so LO-then-HI pairs are coherent
   always_comb begin
      w_ctrl_val = 32'h0;
      w_ctrl_val[MYCLINT_CTRL_EN_BIT] = r_en;
      case (w_sel)
         SEL_MTIME_LO: w_rd_data = r_mtime[31:0];
         SEL_MTIME_HI: w_rd_data = r_shadow;
         SEL_CTRL:     w_rd_data = w_ctrl_val;
         default:      w_rd_data = 32'h0;
      endcase
   end

`ifdef MYCLINT_RTC_EXT_EN
   logic w_rise;

   myclint_rtc_sync u_rtc_sync (
      .clk      (clk),
      .reset    (reset),
      .i_rt_clk (rt_clk),
      .o_rise   (w_rise)
   );

   // External mode: the registered tick follows each synchronized rt_clk edge
   always_comb begin
      w_tick_nxt = w_rise & w_en_nxt;
   end
`else
   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Prescaler next value: advances only while enabled, wraps after CNT_MAX
   always_comb begin
      if (r_en) begin
         if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = '0;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end
      // tick is registered, so it is asserted from the lookahead of the count
      w_tick_nxt = w_en_nxt & (w_cnt_nxt == CNT_MAX);
   end

   // Prescaler count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end
`endif

   // Bus response: one-cycle ready, read data held until the next read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_ready <= w_accept;
         if (w_rd) begin
            r_rdata <= w_rd_data;
         end else begin
            r_rdata <= r_rdata;
         end
      end
   end

   // HI snapshot: captured on MTIME_LO reads, overwritten by MTIME_HI writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow <= 32'h0;
      end else if (w_rd && (w_sel == SEL_MTIME_LO)) begin
         r_shadow <= r_mtime[63:32];
      end else if (w_wr_hi) begin
         r_shadow <= w_hi_new;
      end else begin
         r_shadow <= r_shadow;
      end
   end

   // Enable bit and registered tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en   <= 1'b1;
         r_tick <= 1'b0;
      end else begin
         r_en   <= w_en_nxt;
         r_tick <= w_tick_nxt;
      end
   end

   // mtime: a write to either half drops a coincident increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mtime <= 64'd0;
      end else if (w_wr_lo) begin
         r_mtime[31:0] <= w_lo_new;
      end else if (w_wr_hi) begin
         r_mtime[63:32] <= w_hi_new;
      end else if (r_tick) begin
         r_mtime <= r_mtime + 64'd1;
      end else begin
         r_mtime <= r_mtime;
      end
   end

   assign rdata = r_rdata;
   assign ready = r_ready;
   assign mtime = r_mtime;
   assign tick  = r_tick;

endmodule
